// File: rtl/rah_byte_packer_if.sv
// Byte-stream in / frame-out bundle for the RAH byte packer.
// The master side is the byte source and queue, the slave side is the packer.
interface rah_byte_packer_if #(
  parameter int W = 48
);
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         queue_full;
  logic [W-1:0] data;
  logic         send_data;
  logic         frame_partial;
  logic         overflow;

  modport master (
    output byte_valid, byte_data, queue_full,
    input  data, send_data, frame_partial, overflow
  );

  modport slave (
    input  byte_valid, byte_data, queue_full,
    output data, send_data, frame_partial, overflow
  );
endinterface

// File: rtl/rah_byte_packer.sv
// Packs a uart byte stream MSB-first into RAH frames.
// Idle partial frames are flushed padded; one held frame absorbs backpressure.
module rah_byte_packer #(
  parameter int          RAH_PACKET_WIDTH = 48,
  parameter int          TIMEOUT_CYCLES   = 14040,
  parameter logic [7:0]  PAD_BYTE         = 8'h00
) (
  input logic clk,
  input logic rst_n,
  rah_byte_packer_if.slave bus
);
  localparam int W  = RAH_PACKET_WIDTH;
  localparam int BYTES_IN_PACKET = W / 8;
  localparam int N  = BYTES_IN_PACKET;
  localparam int CW = $clog2(N + 1);
  localparam int IW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [W-1:0]  asm_q, asm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          hvld_q, hvld_d;
  logic          hpart_q, hpart_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [W-1:0]  data_q, data_d;
  logic          send_q, send_d;
  logic          part_q, part_d;
  logic          ovf_q, ovf_d;

  logic          emit, hold_free, full, partial;
  logic          flush_req, xfer, accept;
  logic [CW-1:0] base;
  logic [W-1:0]  padded;

  always_comb begin
    emit      = hvld_q && !bus.queue_full;
    hold_free = !hvld_q || emit;
    full      = (cnt_q == CW'(N));
    partial   = (cnt_q != '0) && !full;
    flush_req = (TIMEOUT_CYCLES != 0) && partial &&
                (idle_q >= IW'(TIMEOUT_CYCLES));
    // An arriving byte wins over a pending flush.
    xfer      = (full || (flush_req && !bus.byte_valid)) && hold_free;
    accept    = bus.byte_valid && (!full || xfer);
    base      = xfer ? '0 : cnt_q;

    padded = asm_q;
    for (int i = 0; i < N; i++) begin
      if (i >= int'(cnt_q)) padded[W-1-8*i -: 8] = PAD_BYTE;
    end

    hold_d  = hold_q;
    hpart_d = hpart_q;
    hvld_d  = hvld_q && !emit;
    if (xfer) begin
      hold_d  = padded;
      hpart_d = !full;
      hvld_d  = 1'b1;
    end

    asm_d = asm_q;
    cnt_d = xfer ? '0 : cnt_q;
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (i == int'(base)) asm_d[W-1-8*i -: 8] = bus.byte_data;
      end
      cnt_d = base + CW'(1);
    end

    idle_d = idle_q;
    if (accept || xfer) begin
      idle_d = '0;
    end else if (partial && !bus.byte_valid &&
                 idle_q < IW'(TIMEOUT_CYCLES)) begin
      idle_d = idle_q + IW'(1);
    end

    data_d = emit ? hold_q : data_q;
    send_d = emit;
    part_d = emit && hpart_q;
    ovf_d  = ovf_q || (bus.byte_valid && !accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      hvld_q  <= 1'b0;
      hpart_q <= 1'b0;
      idle_q  <= '0;
      data_q  <= '0;
      send_q  <= 1'b0;
      part_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      hvld_q  <= hvld_d;
      hpart_q <= hpart_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      send_q  <= send_d;
      part_q  <= part_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.data          = data_q;
  assign bus.send_data     = send_q;
  assign bus.frame_partial = part_q;
  assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_rah_byte_packer.sv
// Bench for rah_byte_packer: directed scenarios plus random streams
// checked against a chunk-and-pad frame model.
module tb_rah_byte_packer;
  localparam int W  = 48;
  localparam int N  = W / 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  rah_byte_packer_if #(.W(W)) ia ();
  rah_byte_packer_if #(.W(W)) ib ();

  rah_byte_packer #(
    .RAH_PACKET_WIDTH(W), .TIMEOUT_CYCLES(TO), .PAD_BYTE(8'h00)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));

  rah_byte_packer #(
    .RAH_PACKET_WIDTH(W), .TIMEOUT_CYCLES(TO), .PAD_BYTE(8'hFF)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  typedef struct {
    int unsigned  c;
    logic [W-1:0] d;
    logic         p;
  } ev_t;
  ev_t qa[$];
  ev_t qb[$];

  always @(negedge clk) begin
    if (ia.send_data === 1'b1) qa.push_back('{cyc, ia.data, ia.frame_partial});
    if (ib.send_data === 1'b1) qb.push_back('{cyc, ib.data, ib.frame_partial});
  end

  task automatic drv(input logic v, input logic [7:0] b, input logic qf);
    @(negedge clk);
    ia.byte_valid = v; ia.byte_data = b; ia.queue_full = qf;
    ib.byte_valid = v; ib.byte_data = b; ib.queue_full = qf;
  endtask

  task automatic idle(input int n, input logic qf);
    repeat (n) drv(1'b0, 8'h00, qf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ia.byte_valid = 1'b0; ia.queue_full = 1'b0;
    ib.byte_valid = 1'b0; ib.queue_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
  endtask

  task automatic test_reset();
    ia.byte_valid = 1'b0; ia.byte_data = 8'h00; ia.queue_full = 1'b0;
    ib.byte_valid = 1'b0; ib.byte_data = 8'h00; ib.queue_full = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (ia.data !== '0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", ia.data);
    end
    checks++;
    if (ia.send_data !== 1'b0) begin
      failures++; $display("FAIL reset_send got=%b exp=0", ia.send_data);
    end
    checks++;
    if (ia.frame_partial !== 1'b0) begin
      failures++; $display("FAIL reset_partial got=%b exp=0", ia.frame_partial);
    end
    checks++;
    if (ia.overflow !== 1'b0) begin
      failures++; $display("FAIL reset_overflow got=%b exp=0", ia.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b0);
  endtask

  task automatic test_complete();
    int unsigned last;
    qa.delete();
    for (int i = 0; i < N; i++) drv(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    last = cyc + 1;
    idle(6, 1'b0);
    checks++;
    if (qa.size() != 1) begin
      failures++; $display("FAIL complete_count got=%0d exp=1", qa.size());
    end else begin
      checks++;
      if (qa[0].d !== 48'h112233445566) begin
        failures++; $display("FAIL complete_data got=%h exp=112233445566", qa[0].d);
      end
      checks++;
      if (qa[0].p !== 1'b0) begin
        failures++; $display("FAIL complete_partial got=%b exp=0", qa[0].p);
      end
      checks++;
      if (qa[0].c != last + 2) begin
        failures++; $display("FAIL complete_latency got=%0d exp=%0d", qa[0].c, last + 2);
      end
    end
  endtask

  task automatic test_timeout();
    int unsigned last;
    qa.delete(); qb.delete();
    drv(1'b1, 8'hAA, 1'b0);
    drv(1'b1, 8'hBB, 1'b0);
    last = cyc + 1;
    idle(TO + 8, 1'b0);
    checks++;
    if (qa.size() != 1) begin
      failures++; $display("FAIL timeout_count got=%0d exp=1", qa.size());
    end else begin
      checks++;
      if (qa[0].d !== 48'hAABB00000000) begin
        failures++; $display("FAIL timeout_data got=%h exp=aabb00000000", qa[0].d);
      end
      checks++;
      if (qa[0].p !== 1'b1) begin
        failures++; $display("FAIL timeout_partial got=%b exp=1", qa[0].p);
      end
      checks++;
      if (qa[0].c != last + TO + 2) begin
        failures++; $display("FAIL timeout_latency got=%0d exp=%0d", qa[0].c, last + TO + 2);
      end
    end
    checks++;
    if (qb.size() != 1) begin
      failures++; $display("FAIL pad_count got=%0d exp=1", qb.size());
    end else begin
      checks++;
      if (qb[0].d !== 48'hAABBFFFFFFFF || qb[0].p !== 1'b1) begin
        failures++; $display("FAIL pad_data got=%h/%b exp=aabbffffffff/1", qb[0].d, qb[0].p);
      end
    end
  endtask

  task automatic test_race();
    qa.delete();
    drv(1'b1, 8'hAA, 1'b0);
    idle(TO, 1'b0);
    drv(1'b1, 8'hCC, 1'b0);
    for (int i = 1; i <= 4; i++) drv(1'b1, 8'(i), 1'b0);
    idle(6, 1'b0);
    checks++;
    if (qa.size() != 1) begin
      failures++; $display("FAIL race_count got=%0d exp=1", qa.size());
    end else begin
      checks++;
      if (qa[0].d !== 48'hAACC01020304 || qa[0].p !== 1'b0) begin
        failures++; $display("FAIL race_data got=%h/%b exp=aacc01020304/0", qa[0].d, qa[0].p);
      end
    end
  endtask

  task automatic test_backpressure();
    qa.delete();
    for (int i = 1; i <= 12; i++) drv(1'b1, 8'(i), 1'b1);
    idle(3, 1'b1);
    checks++;
    if (qa.size() != 0 || ia.overflow !== 1'b0) begin
      failures++; $display("FAIL bp_hold got=%0d/%b exp=0/0", qa.size(), ia.overflow);
    end
    drv(1'b1, 8'h0D, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (ia.overflow !== 1'b1) begin
      failures++; $display("FAIL bp_overflow got=%b exp=1", ia.overflow);
    end
    idle(8, 1'b0);
    checks++;
    if (qa.size() != 2) begin
      failures++; $display("FAIL bp_count got=%0d exp=2", qa.size());
    end else begin
      checks++;
      if (qa[0].d !== 48'h010203040506) begin
        failures++; $display("FAIL bp_frame0 got=%h exp=010203040506", qa[0].d);
      end
      checks++;
      if (qa[1].d !== 48'h0708090A0B0C) begin
        failures++; $display("FAIL bp_frame1 got=%h exp=0708090a0b0c", qa[1].d);
      end
      checks++;
      if (qa[1].c <= qa[0].c || qa[1].c > qa[0].c + 2) begin
        failures++; $display("FAIL bp_gap got=%0d exp=1..2", qa[1].c - qa[0].c);
      end
    end
    checks++;
    if (ia.overflow !== 1'b1) begin
      failures++; $display("FAIL bp_sticky got=%b exp=1", ia.overflow);
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 1; i <= 3; i++) drv(1'b1, 8'(i), 1'b0);
    do_reset();
    for (int i = 1; i <= N; i++) drv(1'b1, 8'(8'hA0 + i), 1'b0);
    idle(TO + 6, 1'b0);
    checks++;
    if (qa.size() != 1) begin
      failures++; $display("FAIL rst_count got=%0d exp=1", qa.size());
    end else begin
      checks++;
      if (qa[0].d !== 48'hA1A2A3A4A5A6 || qa[0].p !== 1'b0) begin
        failures++; $display("FAIL rst_data got=%h/%b exp=a1a2a3a4a5a6/0", qa[0].d, qa[0].p);
      end
    end
    checks++;
    if (ia.overflow !== 1'b0) begin
      failures++; $display("FAIL rst_overflow got=%b exp=0", ia.overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] f;
    qa.delete();
    for (int i = 0; i < 60; i++) drv(1'b1, 8'(i), 1'b0);
    idle(6, 1'b0);
    checks++;
    if (qa.size() != 10) begin
      failures++; $display("FAIL stream_count got=%0d exp=10", qa.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        f = '0;
        for (int j = 0; j < N; j++) f = {f[W-9:0], 8'(k * N + j)};
        checks++;
        if (qa[k].d !== f || qa[k].p !== 1'b0) begin
          failures++; $display("FAIL stream_frame%0d got=%h exp=%h", k, qa[k].d, f);
        end
      end
    end
    checks++;
    if (ia.overflow !== 1'b0) begin
      failures++; $display("FAIL stream_overflow got=%b exp=0", ia.overflow);
    end
  endtask

  task automatic test_random();
    logic [7:0]   bytes[$];
    logic [W-1:0] f;
    int n, nf, idx;
    for (int it = 0; it < 4; it++) begin
      qa.delete();
      bytes.delete();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        bytes.push_back(8'($urandom));
        drv(1'b1, bytes[i], 1'b0);
        idle($urandom_range(0, 3), 1'b0);
      end
      idle(TO + 8, 1'b0);
      nf = (n + N - 1) / N;
      checks++;
      if (qa.size() != nf) begin
        failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, qa.size(), nf);
      end else begin
        for (int k = 0; k < nf; k++) begin
          f = '0;
          for (int j = 0; j < N; j++) begin
            idx = k * N + j;
            f = {f[W-9:0], (idx < n) ? bytes[idx] : 8'h00};
          end
          checks++;
          if (qa[k].d !== f || qa[k].p !== ((k + 1) * N > n)) begin
            failures++;
            $display("FAIL rand%0d_frame%0d got=%h/%b exp=%h/%b",
                     it, k, qa[k].d, qa[k].p, f, (k + 1) * N > n);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_complete();
    test_timeout();
    test_race();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
